// File: rtl/ratio_streamer.sv
// ratio_streamer: snapshots a per-point ratio vector on each ready_ratio
// pulse and emits it as a framed 16-bit valid/ready word stream.
// Frame: header {HDR_TAG, frame_cnt}, one word {idx[3:0], point} per
// point, then an optional mod-2^16 checksum trailer. The trailer is
// built only when RATIO_STREAM_CHECKSUM_EN is defined.
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   ratio            12*POINTS-bit vector, point k at [12*k+11 -: 12]
//   ready_ratio      1-cycle pulse, ratio valid this cycle
//   out_data/valid/ready/last  framed word stream to the host
//   busy             a frame is in flight
//   overrun          sticky flag, a pulse was dropped while busy
//   overrun_cnt      dropped pulses, saturates at 255
//   frame_cnt        accepted frames, wraps 4095 -> 0
module ratio_streamer #(
   parameter int unsigned POINTS  = 10,
   parameter logic [3:0]  HDR_TAG = 4'hA
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [12*POINTS-1:0]  ratio,
   input  logic                  ready_ratio,
   output logic [15:0]           out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overrun,
   output logic [7:0]            overrun_cnt,
   output logic [11:0]           frame_cnt
);

   localparam int unsigned VW       = 12 * POINTS;
   localparam logic [11:0] LAST_IDX = 12'(POINTS - 1);

`ifdef RATIO_STREAM_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HDR, DATA, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

   state_t          state_q, state_d;
   logic [VW-1:0]   snap_q, snap_d;
   logic [11:0]     idx_q, idx_d;
   logic [11:0]     frame_cnt_q, frame_cnt_d;
   logic            overrun_q, overrun_d;
   logic [7:0]      ovr_cnt_q, ovr_cnt_d;
`ifdef RATIO_STREAM_CHECKSUM_EN
   logic [15:0]     chk_q, chk_d;
`endif
   logic            last_hs;
   logic            take;

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;
      ovr_cnt_d   = ovr_cnt_q;
`ifdef RATIO_STREAM_CHECKSUM_EN
      chk_d       = chk_q;
`endif
      out_valid   = 1'b0;
      out_data    = 16'h0000;
      out_last    = 1'b0;

      unique case (state_q)
         IDLE: begin
         end
         HDR: begin
            out_valid = 1'b1;
            out_data  = {HDR_TAG, frame_cnt_q};
            if (out_ready) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            // Snapshot shifts down one point per accepted word, so the
            // current point always sits in the low 12 bits.
            out_valid = 1'b1;
            out_data  = {idx_q[3:0], snap_q[11:0]};
`ifndef RATIO_STREAM_CHECKSUM_EN
            out_last  = (idx_q == LAST_IDX);
`endif
            if (out_ready) begin
               idx_d  = idx_q + 12'd1;
               snap_d = snap_q >> 12;
`ifdef RATIO_STREAM_CHECKSUM_EN
               chk_d  = chk_q + out_data;
`endif
               if (idx_q == LAST_IDX) begin
`ifdef RATIO_STREAM_CHECKSUM_EN
                  state_d = CHK;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef RATIO_STREAM_CHECKSUM_EN
         CHK: begin
            out_valid = 1'b1;
            out_data  = chk_q;
            out_last  = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // A pulse landing on the final handshake starts the next frame
      // with no idle cycle in between.
      last_hs = out_valid && out_ready && out_last;
      take    = ready_ratio && ((state_q == IDLE) || last_hs);

      if (take) begin
         snap_d      = ratio;
         frame_cnt_d = frame_cnt_q + 12'd1;
         state_d     = HDR;
         idx_d       = '0;
`ifdef RATIO_STREAM_CHECKSUM_EN
         chk_d       = 16'h0000;
`endif
      end else if (ready_ratio) begin
         overrun_d = 1'b1;
         if (ovr_cnt_q != 8'hFF) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
         ovr_cnt_q   <= '0;
`ifdef RATIO_STREAM_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
         ovr_cnt_q   <= ovr_cnt_d;
`ifdef RATIO_STREAM_CHECKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   assign busy        = (state_q != IDLE);
   assign overrun     = overrun_q;
   assign overrun_cnt = ovr_cnt_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ratio_streamer.sv
// tb_ratio_streamer: random and directed stimulus for ratio_streamer,
// checked against a frame-level word-queue reference model.
module tb_ratio_streamer;

   localparam int P = 10;
`ifdef RATIO_STREAM_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [12*P-1:0]   ratio = '0;
   logic              ready_ratio = 1'b0;
   logic [15:0]       out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              out_last;
   logic              busy;
   logic              overrun;
   logic [7:0]        overrun_cnt;
   logic [11:0]       frame_cnt;

   ratio_streamer #(.POINTS(P), .HDR_TAG(4'hA)) dut (
      .clock       (clock),
      .reset       (reset),
      .ratio       (ratio),
      .ready_ratio (ready_ratio),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt),
      .frame_cnt   (frame_cnt)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: words still owed to the sink, {last, data}
   logic [16:0] exp_q[$];
   logic [11:0] m_cnt = '0;
   logic        m_ovr = 1'b0;
   int          m_ovr_cnt = 0;
   int          n_acc = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [12*P-1:0] r);
      logic [15:0] sum;
      logic [15:0] w;
      logic [3:0]  kk;
      m_cnt = m_cnt + 12'd1;
      n_acc++;
      exp_q.push_back({1'b0, 4'hA, m_cnt});
      sum = 16'h0000;
      for (int k = 0; k < P; k++) begin
         kk  = 4'(k);
         w   = {kk, r[12*k +: 12]};
         sum = sum + w;
         exp_q.push_back({(k == P - 1) && !CSUM, w});
      end
      if (CSUM) exp_q.push_back({1'b1, sum});
   endtask

   // compare at the negedge, advance model, move to next negedge
   task automatic step();
      bit v;
      bit hs;
      bit lh;
      v = (exp_q.size() != 0);
      check("valid", 32'(out_valid), 32'(v));
      check("busy", 32'(busy), 32'(v));
      if (v) begin
         check("data", 32'(out_data), 32'(exp_q[0][15:0]));
         check("last", 32'(out_last), 32'(exp_q[0][16]));
      end
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("ovr_cnt", 32'(overrun_cnt), 32'(m_ovr_cnt));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      hs = v && out_ready;
      lh = hs && exp_q[0][16];
      if (hs) void'(exp_q.pop_front());
      if (ready_ratio) begin
         if (!v || lh) begin
            push_frame(ratio);
         end else begin
            m_ovr = 1'b1;
            if (m_ovr_cnt < 255) m_ovr_cnt++;
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic rand_ratio();
      for (int k = 0; k < P; k++) ratio[12*k +: 12] = 12'($urandom);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cnt     = '0;
      m_ovr     = 1'b0;
      m_ovr_cnt = 0;
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clock);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_last", 32'(out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovr", 32'(overrun), 0);
      check("rst_ovr_cnt", 32'(overrun_cnt), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      reset = 1'b0;
      step();

      // directed frame: points 1..10, sink always ready
      for (int k = 0; k < P; k++) ratio[12*k +: 12] = 12'(k + 1);
      out_ready   = 1'b1;
      ready_ratio = 1'b1;
      step();
      ready_ratio = 1'b0;
      ratio       = '1;
      check("first_hdr", 32'(out_data), 32'h0000A001);
      check("first_valid", 32'(out_valid), 1);
      step();
      check("first_w0", 32'(out_data), 32'h00000001);
      repeat (P + 4) step();

      // same frame with a toggling sink
      for (int k = 0; k < P; k++) ratio[12*k +: 12] = 12'(k + 1);
      ready_ratio = 1'b1;
      out_ready   = 1'b0;
      step();
      ready_ratio = 1'b0;
      for (int i = 0; i < 2 * (P + 3); i++) begin
         out_ready = ~out_ready;
         if (i == 3) ready_ratio = 1'b1;
         step();
         ready_ratio = 1'b0;
         rand_ratio();
      end
      out_ready = 1'b1;
      repeat (4) step();

      // pulse coincident with the last handshake
      rand_ratio();
      ready_ratio = 1'b1;
      step();
      ready_ratio = 1'b0;
      cyc = 0;
      while (exp_q.size() != 1 && cyc < 100) begin
         step();
         cyc++;
      end
      check("b2b_reach", 32'(exp_q.size()), 1);
      rand_ratio();
      ready_ratio = 1'b1;
      step();
      ready_ratio = 1'b0;
      check("b2b_valid", 32'(out_valid), 1);
      repeat (P + 4) step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rand_ratio();
         out_ready   = ($urandom_range(0, 3) != 0);
         ready_ratio = ($urandom_range(0, 9) == 0);
         step();
      end
      ready_ratio = 1'b0;
      out_ready   = 1'b1;
      repeat (P + 4) step();

      // reset in the middle of DATA idx 4
      rand_ratio();
      ready_ratio = 1'b1;
      step();
      ready_ratio = 1'b0;
      repeat (5) step();
      check("mid_idx4", 32'(out_data[15:12]), 4);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_frame", 32'(frame_cnt), 0);
      check("mid_rst_ovr", 32'(overrun_cnt), 0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      step();
      rand_ratio();
      ready_ratio = 1'b1;
      step();
      ready_ratio = 1'b0;
      check("post_rst_hdr", 32'(out_data), 32'h0000A001);

      // continuous pulses: back-to-back frames through the 4095 wrap
      ready_ratio = 1'b1;
      cyc = 0;
      n_acc = 0;
      while (n_acc < 4098 && cyc < 60000) begin
         rand_ratio();
         step();
         cyc++;
      end
      check("wrap_reach", 32'(n_acc >= 4098), 1);
      ready_ratio = 1'b0;
      repeat (P + 4) step();
      check("wrap_cnt", 32'(frame_cnt), 32'(m_cnt));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
